// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU writeback FIFOs feeding a single registered common data bus.
// Round-robin grant over valid FIFO heads, speculative squash/promote on branch resolution.
module cdb_arbiter #(
  parameter int unsigned NUM_FU     = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ISS_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_FU-1:0]        fu_valid_i,
  output logic [NUM_FU-1:0]        fu_ready_o,
  input  logic [5*NUM_FU-1:0]      fu_reg_i,
  input  logic [ISS_W*NUM_FU-1:0]  fu_iss_i,
  input  logic [32*NUM_FU-1:0]     fu_data_i,
  input  logic [NUM_FU-1:0]        fu_spec_i,
  input  logic                     prediction_failed,
  input  logic                     prediction_success,
  output logic                     CDB_EN,
  output logic [4:0]               CDB_REG_ID,
  output logic [31:0]              CDB_ISS_ID,
  output logic [31:0]              CDB_DATA
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic             valid;
    logic             spec;
    logic [4:0]       dest;
    logic [ISS_W-1:0] iss;
    logic [31:0]      data;
  } entry_t;

  entry_t           mem    [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr [NUM_FU];
  logic [PTR_W-1:0] wr_ptr [NUM_FU];
  logic [CNT_W-1:0] count  [NUM_FU];
  logic [FU_W-1:0]  rr_ptr;

  entry_t           head     [NUM_FU];
  entry_t           wr_entry [NUM_FU];
  logic [NUM_FU-1:0] nonempty;
  logic [NUM_FU-1:0] eligible;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic              grant_vld;
  logic [FU_W-1:0]   grant_idx;
  logic [FU_W:0]     cand;
  logic [FU_W-1:0]   next_rr;
  entry_t            grant_head;

  // Head view, eligibility and ready, all from registered FIFO state
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      head[k]       = mem[k][rd_ptr[k]];
      nonempty[k]   = (count[k] != '0);
      eligible[k]   = nonempty[k] && head[k].valid;
      fu_ready_o[k] = (count[k] < CNT_W'(FIFO_DEPTH));
    end
  end

  // Round-robin search starting at rr_ptr over eligible heads
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      cand = {1'b0, rr_ptr} + (FU_W+1)'(i);
      if (cand >= (FU_W+1)'(NUM_FU)) begin
        cand = cand - (FU_W+1)'(NUM_FU);
      end
      if (!grant_vld && eligible[cand[FU_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[FU_W-1:0];
      end
    end
    grant_head = head[grant_idx];
    next_rr    = (grant_idx == FU_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Push filter and pop selection: granted head, or a squashed head drained silently
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      pop[k]  = nonempty[k] &&
                ((grant_vld && (grant_idx == FU_W'(k))) || !head[k].valid);
      push[k] = fu_valid_i[k] && fu_ready_o[k] &&
                (fu_reg_i[5*k +: 5] != 5'd0) &&
                !(fu_spec_i[k] && prediction_failed);
      wr_entry[k].valid = 1'b1;
      wr_entry[k].spec  = fu_spec_i[k] && !prediction_success;
      wr_entry[k].dest  = fu_reg_i[5*k +: 5];
      wr_entry[k].iss   = fu_iss_i[ISS_W*k +: ISS_W];
      wr_entry[k].data  = fu_data_i[32*k +: 32];
    end
  end

  // FIFO storage, pointers and speculative-flag maintenance
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_FU; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        count[k]  <= '0;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          mem[k][e] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          if (prediction_failed) begin
            if (mem[k][e].spec) begin
              mem[k][e].valid <= 1'b0;
            end
          end else if (prediction_success) begin
            mem[k][e].spec <= 1'b0;
          end
        end
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= wr_entry[k];
          wr_ptr[k]         <= wr_ptr[k] + 1'b1;
        end
        if (pop[k]) begin
          rd_ptr[k] <= rd_ptr[k] + 1'b1;
        end
        count[k] <= count[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
      end
    end
  end

  // Round-robin pointer and registered CDB broadcast
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      CDB_EN     <= 1'b0;
      CDB_REG_ID <= '0;
      CDB_ISS_ID <= '0;
      CDB_DATA   <= '0;
    end else begin
      CDB_EN <= 1'b0;
      if (grant_vld) begin
        rr_ptr <= next_rr;
        if (!(prediction_failed && grant_head.spec)) begin
          CDB_EN     <= 1'b1;
          CDB_REG_ID <= grant_head.dest;
          CDB_ISS_ID <= 32'(grant_head.iss);
          CDB_DATA   <= grant_head.data;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a queue-level model of buffering, round-robin and speculation rules.
module tb_cdb_arbiter;

  localparam int NF  = 4;
  localparam int DEP = 2;
  localparam int IW  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] fu_valid = '0;
  logic [NF-1:0] fu_spec = '0;
  logic [NF-1:0] fu_ready;
  logic [5*NF-1:0]  fu_reg = '0;
  logic [IW*NF-1:0] fu_iss = '0;
  logic [32*NF-1:0] fu_data = '0;
  logic pf = 1'b0;
  logic ps = 1'b0;
  logic        cdb_en;
  logic [4:0]  cdb_reg;
  logic [31:0] cdb_iss;
  logic [31:0] cdb_data;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(NF), .FIFO_DEPTH(DEP), .ISS_W(IW)) dut (
    .clk(clk), .reset(reset),
    .fu_valid_i(fu_valid), .fu_ready_o(fu_ready),
    .fu_reg_i(fu_reg), .fu_iss_i(fu_iss), .fu_data_i(fu_data), .fu_spec_i(fu_spec),
    .prediction_failed(pf), .prediction_success(ps),
    .CDB_EN(cdb_en), .CDB_REG_ID(cdb_reg), .CDB_ISS_ID(cdb_iss), .CDB_DATA(cdb_data)
  );

  typedef struct packed {
    bit        valid;
    bit        spec;
    bit [4:0]  dest;
    bit [7:0]  iss;
    bit [31:0] data;
  } ent_t;

  // Model: each FU buffer is an ordered list, index 0 is the oldest
  ent_t      mq [NF][DEP];
  int        mcnt [NF];
  int        rr;
  bit        m_en;
  bit [4:0]  m_reg;
  bit [31:0] m_iss;
  bit [31:0] m_data;
  bit        last_xfer [NF];
  int        n_chk = 0;
  int        n_fail = 0;
  bit        started = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mpop(input int k);
    for (int i = 0; i < DEP - 1; i++) mq[k][i] = mq[k][i+1];
    mcnt[k]--;
  endtask

  // One clock of the rules, evaluated on the inputs presented before the edge
  task automatic model_step();
    bit xfer [NF];
    int g;
    ent_t e;
    if (reset) begin
      for (int k = 0; k < NF; k++) begin mcnt[k] = 0; last_xfer[k] = 0; end
      rr = 0; m_en = 0; m_reg = 0; m_iss = 0; m_data = 0;
      return;
    end
    for (int k = 0; k < NF; k++) xfer[k] = fu_valid[k] && (mcnt[k] < DEP);
    g = -1;
    for (int i = 0; i < NF; i++) begin
      int k;
      k = (rr + i) % NF;
      if (g < 0 && mcnt[k] > 0 && mq[k][0].valid) g = k;
    end
    m_en = 0;
    if (g >= 0) begin
      if (!(pf && mq[g][0].spec)) begin
        m_en = 1; m_reg = mq[g][0].dest; m_iss = 32'(mq[g][0].iss); m_data = mq[g][0].data;
      end
      rr = (g + 1) % NF;
      mpop(g);
    end
    for (int k = 0; k < NF; k++)
      if (k != g && mcnt[k] > 0 && !mq[k][0].valid) mpop(k);
    for (int k = 0; k < NF; k++)
      for (int i = 0; i < mcnt[k]; i++) begin
        if (pf) begin
          if (mq[k][i].spec) mq[k][i].valid = 0;
        end else if (ps) begin
          mq[k][i].spec = 0;
        end
      end
    for (int k = 0; k < NF; k++) begin
      last_xfer[k] = xfer[k];
      if (xfer[k] && fu_reg[5*k +: 5] != 5'd0 && !(fu_spec[k] && pf)) begin
        e.valid = 1; e.spec = fu_spec[k] && !ps; e.dest = fu_reg[5*k +: 5];
        e.iss = fu_iss[IW*k +: IW]; e.data = fu_data[32*k +: 32];
        mq[k][mcnt[k]] = e;
        mcnt[k]++;
      end
    end
  endtask

  task automatic compare_model();
    logic [NF-1:0] rdy;
    for (int k = 0; k < NF; k++) rdy[k] = (mcnt[k] < DEP);
    check("ready", 32'(fu_ready), 32'(rdy));
    check("cdb_en", 32'(cdb_en), 32'(m_en));
    check("cdb_reg", 32'(cdb_reg), 32'(m_reg));
    check("cdb_iss", cdb_iss, m_iss);
    check("cdb_data", cdb_data, m_data);
  endtask

  // Compare at negedge, advance the model, then cross the rising edge
  task automatic step();
    @(negedge clk);
    if (started) compare_model();
    if (reset) started = 1'b1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int k, input bit v, input bit sp, input bit [4:0] dst,
                        input bit [7:0] iss, input bit [31:0] dat);
    fu_valid[k] = v; fu_spec[k] = sp;
    fu_reg[5*k +: 5] = dst; fu_iss[IW*k +: IW] = iss; fu_data[32*k +: 32] = dat;
  endtask

  task automatic idle_inputs();
    fu_valid = '0; fu_spec = '0; pf = 0; ps = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); reset = 1; step(); reset = 0;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < NF; k++) begin
      if (fu_valid[k] && !last_xfer[k]) continue;
      set_fu(k, $urandom_range(0, 99) < 60, $urandom_range(0, 2) == 0,
             5'($urandom), 8'($urandom), $urandom);
    end
    pf    = ($urandom_range(0, 15) == 0);
    ps    = ($urandom_range(0, 11) == 0);
    reset = ($urandom_range(0, 399) == 0);
  endtask

  int seq [NF];

  initial begin
    do_reset();

    // T1: single result, two-edge latency, then idle
    set_fu(0, 1, 0, 5'd3, 8'h11, 32'hDEAD);
    step();
    idle_inputs();
    step();
    check("t1_en", 32'(cdb_en), 32'd1);
    check("t1_reg", 32'(cdb_reg), 32'd3);
    check("t1_iss", cdb_iss, 32'h11);
    check("t1_data", cdb_data, 32'hDEAD);
    step();
    check("t1_en_off", 32'(cdb_en), 32'd0);

    // T2: all FUs streaming, strict rotation
    do_reset();
    for (int k = 0; k < NF; k++) begin seq[k] = 1; set_fu(k, 1, 0, 5'(k + 1), 8'(k * 64), $urandom); end
    step();
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < NF; k++)
        if (last_xfer[k]) begin
          set_fu(k, 1, 0, 5'(k + 1), 8'(k * 64 + seq[k]), $urandom);
          seq[k]++;
        end
      step();
      check("t2_en", 32'(cdb_en), 32'd1);
      check("t2_order", 32'(cdb_iss[7:6]), 32'(n % 4));
      if (n == 0) check("t2_ready", 32'(fu_ready), 32'b0001);
    end

    // T3: FU2 backpressured while FU0/FU1 are served first
    do_reset();
    set_fu(0, 1, 0, 5'd1, 8'h30, 32'h1);
    set_fu(1, 1, 0, 5'd2, 8'h31, 32'h2);
    set_fu(2, 1, 0, 5'd4, 8'h40, 32'hA);
    step();
    fu_valid[0] = 0; fu_valid[1] = 0;
    set_fu(2, 1, 0, 5'd4, 8'h41, 32'hB);
    step();
    set_fu(2, 1, 0, 5'd4, 8'h42, 32'hC0FFEE);
    check("t3_full", 32'(fu_ready[2]), 32'd0);
    step();
    check("t3_still_full", 32'(fu_ready[2]), 32'd0);
    step();
    check("t3_ready_back", 32'(fu_ready[2]), 32'd1);
    check("t3_iss40", cdb_iss, 32'h40);
    step();
    fu_valid[2] = 0;
    step();
    check("t3_held_iss", cdb_iss, 32'h42);
    check("t3_held_data", cdb_data, 32'hC0FFEE);

    // T4: mispredict squashes two speculative entries behind a committed one
    do_reset();
    set_fu(0, 1, 0, 5'd7, 8'hA0, 32'h100);
    set_fu(1, 1, 0, 5'd8, 8'h04, 32'h4);
    step();
    set_fu(0, 1, 0, 5'd7, 8'hA1, 32'h101);
    set_fu(1, 1, 1, 5'd8, 8'h05, 32'h5);
    step();
    fu_valid[0] = 0;
    set_fu(1, 1, 1, 5'd8, 8'h06, 32'h6);
    step();
    check("t4_en", 32'(cdb_en), 32'd1);
    check("t4_iss4", cdb_iss, 32'h4);
    step();
    fu_valid[1] = 0; pf = 1;
    step();
    pf = 0;
    check("t4_sup", 32'(cdb_en), 32'd0);
    step();
    check("t4_drain", 32'(cdb_en), 32'd0);
    step();
    check("t4_empty_en", 32'(cdb_en), 32'd0);
    check("t4_ready", 32'(fu_ready), 32'hF);

    // T5: failure wins over success; success alone promotes
    do_reset();
    set_fu(3, 1, 1, 5'd9, 8'h09, 32'h9);
    step();
    fu_valid[3] = 0; pf = 1; ps = 1;
    step();
    pf = 0; ps = 0;
    check("t5_squash", 32'(cdb_en), 32'd0);
    step();
    check("t5_gone", 32'(cdb_en), 32'd0);
    set_fu(3, 1, 1, 5'd9, 8'h09, 32'h9);
    step();
    fu_valid[3] = 0; ps = 1;
    step();
    ps = 0;
    check("t5_promote_en", 32'(cdb_en), 32'd1);
    check("t5_promote_iss", cdb_iss, 32'h9);

    // T6: register-zero transfer is swallowed; reset while full
    set_fu(0, 1, 0, 5'd0, 8'h77, 32'h77);
    step();
    fu_valid[0] = 0;
    check("t6_r0_ready", 32'(fu_ready), 32'hF);
    step();
    check("t6_r0_none", 32'(cdb_en), 32'd0);
    for (int k = 0; k < NF; k++) set_fu(k, 1, 0, 5'(k + 5), 8'(k + 16), $urandom);
    step(); step();
    idle_inputs(); reset = 1;
    step();
    reset = 0;
    check("t6_rst_en", 32'(cdb_en), 32'd0);
    check("t6_rst_ready", 32'(fu_ready), 32'hF);
    step();
    check("t6_rst_nobc", 32'(cdb_en), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rand_inputs();
      step();
    end
    reset = 0;
    idle_inputs();
    for (int c = 0; c < 6; c++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
